// File: rtl/picorv_mem_arbiter.sv
// Two-master arbiter sharing one PicoRV32-native memory port.
// Each transfer is registered, held until completion and bounded by a watchdog.
module picorv_mem_arbiter #(
    parameter int unsigned FIXED_PRIO     = 0,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic        HCLK,
    input  logic        HRESETn,

    input  logic        m0_valid,
    input  logic        m0_instr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,

    input  logic        m1_valid,
    input  logic        m1_instr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,

    output logic        s_valid,
    output logic        s_instr,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,

    output logic        owner,
    output logic        timeout_err
);

    localparam int unsigned CNT_W    = 16;
    localparam int unsigned DATA_W   = 32;
    localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] TO_PRE = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_RESP
    } state_t;

    typedef struct packed {
        logic              instr;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [3:0]        wstrb;
    } req_t;

    state_t            state;
    req_t              s_req_q;
    logic              last_owner;
    logic [CNT_W-1:0]  wd_cnt;

    req_t              m0_req_c;
    req_t              m1_req_c;
    req_t              grant_req_c;
    logic              grant_sel_c;
    logic              expired_c;
    logic              done_c;
    logic [DATA_W-1:0] done_data_c;

    assign m0_req_c = '{instr: m0_instr, addr: m0_addr, wdata: m0_wdata, wstrb: m0_wstrb};
    assign m1_req_c = '{instr: m1_instr, addr: m1_addr, wdata: m1_wdata, wstrb: m1_wstrb};

    assign s_instr = s_req_q.instr;
    assign s_addr  = s_req_q.addr;
    assign s_wdata = s_req_q.wdata;
    assign s_wstrb = s_req_q.wstrb;

    // Winner selection: on a tie, fixed priority favours m0, round-robin favours the non-last owner
    always_comb begin
        grant_sel_c = 1'b0;
        if (m0_valid && m1_valid) begin
            grant_sel_c = (FIXED_PRIO != 0) ? 1'b0 : ~last_owner;
        end else begin
            grant_sel_c = m1_valid;
        end
        grant_req_c = grant_sel_c ? m1_req_c : m0_req_c;
    end

    // Completion of the downstream transfer; expiry wins if it coincides with s_ready
    always_comb begin
        expired_c   = (wd_cnt == TO_LIM);
        done_c      = expired_c || s_ready;
        done_data_c = expired_c ? ERR_RDATA : s_rdata;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state       <= ST_IDLE;
            s_valid     <= 1'b0;
            s_req_q     <= '0;
            owner       <= 1'b0;
            last_owner  <= 1'b1;
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
            m0_ready    <= 1'b0;
            m1_ready    <= 1'b0;
            m0_rdata    <= '0;
            m1_rdata    <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (m0_valid || m1_valid) begin
                        s_req_q <= grant_req_c;
                        owner   <= grant_sel_c;
                        s_valid <= 1'b1;
                        wd_cnt  <= '0;
                        state   <= ST_BUSY;
                    end
                end

                ST_BUSY: begin
                    if (done_c) begin
                        s_valid     <= 1'b0;
                        timeout_err <= 1'b0;
                        state       <= ST_RESP;
                        if (owner) begin
                            m1_ready <= 1'b1;
                            m1_rdata <= done_data_c;
                        end else begin
                            m0_ready <= 1'b1;
                            m0_rdata <= done_data_c;
                        end
                    end else begin
                        if (wd_cnt != '1) begin
                            wd_cnt <= wd_cnt + CNT_W'(1);
                        end
                        // Registered so the pulse lines up with the cycle the limit is reached
                        timeout_err <= (wd_cnt == TO_PRE);
                    end
                end

                ST_RESP: begin
                    m0_ready   <= 1'b0;
                    m1_ready   <= 1'b0;
                    m0_rdata   <= '0;
                    m1_rdata   <= '0;
                    last_owner <= owner;
                    state      <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_picorv_mem_arbiter.sv
// Directed bench for picorv_mem_arbiter: a round-robin and a fixed-priority instance share stimulus.
module tb_picorv_mem_arbiter;

    localparam int TO = 8;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        m0_valid, m0_instr, m1_valid, m1_instr;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        s_ready;
    logic [31:0] s_rdata;

    logic        rr_m0_ready, rr_m1_ready, rr_s_valid, rr_s_instr, rr_owner, rr_timeout_err;
    logic [31:0] rr_m0_rdata, rr_m1_rdata, rr_s_addr, rr_s_wdata;
    logic [3:0]  rr_s_wstrb;
    logic        fp_m0_ready, fp_m1_ready, fp_s_valid, fp_s_instr, fp_owner, fp_timeout_err;
    logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_s_addr, fp_s_wdata;
    logic [3:0]  fp_s_wstrb;

    picorv_mem_arbiter #(.FIXED_PRIO(0), .TIMEOUT_CYCLES(TO), .ERR_RDATA(32'hDEAD_BEEF)) dut_rr (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_wstrb(m0_wstrb), .m0_ready(rr_m0_ready), .m0_rdata(rr_m0_rdata),
        .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_wstrb(m1_wstrb), .m1_ready(rr_m1_ready), .m1_rdata(rr_m1_rdata),
        .s_valid(rr_s_valid), .s_instr(rr_s_instr), .s_addr(rr_s_addr), .s_wdata(rr_s_wdata),
        .s_wstrb(rr_s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata),
        .owner(rr_owner), .timeout_err(rr_timeout_err)
    );

    picorv_mem_arbiter #(.FIXED_PRIO(1), .TIMEOUT_CYCLES(TO), .ERR_RDATA(32'hDEAD_BEEF)) dut_fp (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_wstrb(m0_wstrb), .m0_ready(fp_m0_ready), .m0_rdata(fp_m0_rdata),
        .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_wstrb(m1_wstrb), .m1_ready(fp_m1_ready), .m1_rdata(fp_m1_rdata),
        .s_valid(fp_s_valid), .s_instr(fp_s_instr), .s_addr(fp_s_addr), .s_wdata(fp_s_wdata),
        .s_wstrb(fp_s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata),
        .owner(fp_owner), .timeout_err(fp_timeout_err)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic        mst;
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          waits;
        logic [31:0] srdata;
        logic [31:0] exp_rdata;
        logic        exp_to;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic mst, input logic v, input logic ins, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] ws);
        if (mst) begin
            m1_valid = v; m1_instr = ins; m1_addr = a; m1_wdata = wd; m1_wstrb = ws;
        end else begin
            m0_valid = v; m0_instr = ins; m0_addr = a; m0_wdata = wd; m0_wstrb = ws;
        end
    endtask

    function automatic logic [31:0] rr_rdy(input logic m);
        return m ? 32'(rr_m1_ready) : 32'(rr_m0_ready);
    endfunction

    function automatic logic [31:0] rr_rd(input logic m);
        return m ? rr_m1_rdata : rr_m0_rdata;
    endfunction

    task automatic check_zero(input string tag);
        chk({tag, "_rr_s_valid"}, 32'(rr_s_valid), 32'h0);
        chk({tag, "_rr_s_addr"}, rr_s_addr, 32'h0);
        chk({tag, "_rr_s_wdata"}, rr_s_wdata, 32'h0);
        chk({tag, "_rr_s_ctl"}, {27'h0, rr_s_instr, rr_s_wstrb}, 32'h0);
        chk({tag, "_rr_ready"}, {30'h0, rr_m1_ready, rr_m0_ready}, 32'h0);
        chk({tag, "_rr_rdata"}, rr_m0_rdata | rr_m1_rdata, 32'h0);
        chk({tag, "_rr_owner_to"}, {30'h0, rr_owner, rr_timeout_err}, 32'h0);
        chk({tag, "_fp_s_valid"}, 32'(fp_s_valid), 32'h0);
        chk({tag, "_fp_ready"}, {30'h0, fp_m1_ready, fp_m0_ready}, 32'h0);
        chk({tag, "_fp_owner_to"}, {30'h0, fp_owner, fp_timeout_err}, 32'h0);
    endtask

    // One single-master transfer; starts and ends just after a rising edge with the DUT idle
    task automatic run_vec(input vec_t v);
        bit done = 1'b0;
        drive(v.mst, 1'b1, v.instr, v.addr, v.wdata, v.wstrb);
        s_rdata = v.srdata;
        s_ready = 1'b0;
        @(negedge HCLK);
        chk("idle_s_valid", 32'(rr_s_valid), 32'h0);
        for (int c = 1; c <= 1 + TO && !done; c++) begin
            @(posedge HCLK); #1;
            s_ready = (c == 1 + v.waits);
            @(negedge HCLK);
            chk("busy_s_valid", 32'(rr_s_valid), 32'h1);
            chk("busy_s_addr", rr_s_addr, v.addr);
            chk("busy_s_wdata", rr_s_wdata, v.wdata);
            chk("busy_s_ctl", {27'h0, rr_s_instr, rr_s_wstrb}, {27'h0, v.instr, v.wstrb});
            chk("busy_owner", 32'(rr_owner), 32'(v.mst));
            chk("busy_timeout_err", 32'(rr_timeout_err), 32'(v.exp_to && (c == 1 + TO)));
            chk("busy_no_ready", {30'h0, rr_m1_ready, rr_m0_ready}, 32'h0);
            if (c == 1 + v.waits || c == 1 + TO) done = 1'b1;
        end
        @(posedge HCLK); #1;
        s_ready = 1'b0;
        @(negedge HCLK);
        chk("resp_ready", rr_rdy(v.mst), 32'h1);
        chk("resp_rdata", rr_rd(v.mst), v.exp_rdata);
        chk("resp_other_ready", rr_rdy(~v.mst), 32'h0);
        chk("resp_other_rdata", rr_rd(~v.mst), 32'h0);
        chk("resp_s_valid", 32'(rr_s_valid), 32'h0);
        chk("resp_timeout_err", 32'(rr_timeout_err), 32'h0);
        @(posedge HCLK); #1;
        drive(v.mst, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge HCLK);
        chk("post_ready", {30'h0, rr_m1_ready, rr_m0_ready}, 32'h0);
        chk("post_rdata", rr_m0_rdata | rr_m1_rdata, 32'h0);
        @(posedge HCLK); #1;
    endtask

    vec_t vecs[6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        vecs[0] = '{1'b0, 1'b0, 32'h4000_0000, 32'h0, 4'h0, 2, 32'h1234_5678, 32'h1234_5678, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 32'h8000_0010, 32'hA5A5_0000, 4'b1100, 1, 32'h0, 32'h0, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 32'h0000_0100, 32'h0, 4'h0, 0, 32'h0000_0013, 32'h0000_0013, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 32'h2000_0004, 32'h0, 4'h0, TO - 1, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 32'h4000_0008, 32'h0, 4'h0, 99, 32'h5555_5555, 32'hDEAD_BEEF, 1'b1};
        vecs[5] = '{1'b0, 1'b0, 32'h4000_000C, 32'h0, 4'h0, 0, 32'h1111_2222, 32'h1111_2222, 1'b0};

        HRESETn = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        s_ready = 1'b0;
        s_rdata = 32'h0;
        repeat (2) @(posedge HCLK);
        #1;
        check_zero("reset");
        @(negedge HCLK);
        HRESETn = 1'b1;
        @(posedge HCLK); #1;

        // Continuous tie from reset: round-robin alternates, fixed priority always serves m0
        drive(1'b0, 1'b1, 1'b0, 32'h0000_1000, 32'h0, 4'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h0000_2000, 32'h0, 4'h0);
        for (int i = 0; i < 4; i++) begin
            logic exp_m;
            exp_m = (i % 2) != 0;
            @(posedge HCLK); #1;
            s_ready = 1'b1;
            s_rdata = 32'hC0DE_0000 + 32'(i);
            @(negedge HCLK);
            chk("tie_s_valid", 32'(rr_s_valid), 32'h1);
            chk("tie_owner", 32'(rr_owner), 32'(exp_m));
            chk("tie_s_addr", rr_s_addr, exp_m ? 32'h0000_2000 : 32'h0000_1000);
            chk("tie_fp_owner", 32'(fp_owner), 32'h0);
            @(posedge HCLK); #1;
            s_ready = 1'b0;
            @(negedge HCLK);
            chk("tie_ready", rr_rdy(exp_m), 32'h1);
            chk("tie_rdata", rr_rd(exp_m), 32'hC0DE_0000 + 32'(i));
            chk("tie_other_ready", rr_rdy(~exp_m), 32'h0);
            chk("tie_fp_ready", {30'h0, fp_m1_ready, fp_m0_ready}, 32'h1);
            @(posedge HCLK); #1;
            @(negedge HCLK);
            chk("tie_idle_s_valid", 32'(rr_s_valid), 32'h0);
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(posedge HCLK); #1;

        // s_ready outside BUSY must be ignored
        s_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge HCLK);
            chk("idle_sready_s_valid", 32'(rr_s_valid), 32'h0);
            chk("idle_sready_ready", {30'h0, rr_m1_ready, rr_m0_ready}, 32'h0);
            @(posedge HCLK); #1;
        end
        s_ready = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i]);
        end

        // Reset in the middle of an m1 transfer; last completed owner is m0 at this point
        drive(1'b1, 1'b1, 1'b0, 32'h3000_0000, 32'h0, 4'h0);
        @(posedge HCLK); #1;
        @(negedge HCLK);
        chk("rst_busy_s_valid", 32'(rr_s_valid), 32'h1);
        chk("rst_busy_owner", 32'(rr_owner), 32'h1);
        #2;
        HRESETn = 1'b0;
        #1;
        check_zero("async_rst");
        s_ready = 1'b1;
        s_rdata = 32'h7777_7777;
        @(posedge HCLK); #1;
        @(negedge HCLK);
        check_zero("held_rst");
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        s_ready = 1'b0;
        HRESETn = 1'b1;
        @(posedge HCLK); #1;

        drive(1'b0, 1'b1, 1'b0, 32'h0000_1000, 32'h0, 4'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h0000_2000, 32'h0, 4'h0);
        @(posedge HCLK); #1;
        s_ready = 1'b1;
        s_rdata = 32'h0BAD_F00D;
        @(negedge HCLK);
        chk("post_rst_tie_owner", 32'(rr_owner), 32'h0);
        chk("post_rst_tie_addr", rr_s_addr, 32'h0000_1000);
        @(posedge HCLK); #1;
        s_ready = 1'b0;
        @(negedge HCLK);
        chk("post_rst_m0_ready", 32'(rr_m0_ready), 32'h1);
        chk("post_rst_m0_rdata", rr_m0_rdata, 32'h0BAD_F00D);
        chk("post_rst_m1_ready", 32'(rr_m1_ready), 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (3) @(posedge HCLK);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
